// File: rtl/q1_pkg.sv
// Shared types and constants for the q1 sweep controller and its evaluator.
package q1_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} q1_state_e;

  localparam logic [15:0] Q1_GOLDEN_DEFAULT = 16'hF830;
  localparam int          Q1_NVEC           = 16;

  function automatic logic [4:0] q1_popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/q1_sweep_ctrl_if.sv
// Self-test / external-requester bus of q1_sweep_ctrl; slave is the controller side.
interface q1_sweep_ctrl_if;
  logic        start;
  logic        ext_req;
  logic [3:0]  ext_abcd;
  logic        ext_gnt;
  logic        ext_f;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] result;
  logic [4:0]  err_cnt;

  modport slave (
    input  start, ext_req, ext_abcd,
    output ext_gnt, ext_f, busy, done, pass, result, err_cnt
  );

  modport master (
    output start, ext_req, ext_abcd,
    input  ext_gnt, ext_f, busy, done, pass, result, err_cnt
  );
endinterface

// File: rtl/q1_f_eval.sv
// Combinational evaluator F = A(B + CD) + B~C.
module q1_f_eval (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_f
);
  assign o_f = (i_a & (i_b | (i_c & i_d))) | (i_b & ~i_c);
endmodule

// File: rtl/q1_sweep_ctrl.sv
// Sweeps all 16 vectors through q1_f_eval, checks the truth table, and arbitrates
// the evaluator to an external requester when idle. Q1_SWEEP_ERRCNT_EN enables err_cnt.
module q1_sweep_ctrl
  import q1_pkg::*;
#(
  parameter logic [15:0] GOLDEN = Q1_GOLDEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  q1_sweep_ctrl_if.slave  bus
);

  localparam int          IW   = $clog2(Q1_NVEC);
  localparam logic [IW-1:0] LAST = IW'(Q1_NVEC - 1);

  q1_state_e   r_state, w_state_nxt;
  logic [IW-1:0] r_idx, r_abcd_q, r_cap_idx;
  logic        r_cap_vld;
  logic [15:0] r_result, w_result_nxt;
  logic        r_pass;
  logic        w_busy, w_start_acc, w_done_entry, w_f;
  logic [3:0]  w_eval_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy       = 1'b0;
    w_start_acc  = 1'b0;
    w_done_entry = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state_nxt = RUN;
        w_start_acc = 1'b1;
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_idx == LAST) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        w_busy       = 1'b1;
        w_done_entry = 1'b1;
        w_state_nxt  = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Evaluator is shared: sweep vector while busy, otherwise the external inputs.
  assign w_eval_in = w_busy ? 4'(r_abcd_q) : bus.ext_abcd;

  q1_f_eval u_eval (
    .i_a (w_eval_in[3]),
    .i_b (w_eval_in[2]),
    .i_c (w_eval_in[1]),
    .i_d (w_eval_in[0]),
    .o_f (w_f)
  );

  always_comb begin
    w_result_nxt = r_result;
    if (r_cap_vld) w_result_nxt[r_cap_idx] = w_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_abcd_q  <= '0;
      r_cap_idx <= '0;
      r_cap_vld <= 1'b0;
      r_result  <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_cap_vld <= (r_state == RUN);
      if (r_state == RUN) begin
        r_abcd_q  <= r_idx;
        r_cap_idx <= r_idx;
        r_idx     <= r_idx + 1'b1;
      end
      if (w_start_acc) begin
        r_idx    <= '0;
        r_result <= '0;
        r_pass   <= 1'b0;
      end else if (r_cap_vld) begin
        r_result <= w_result_nxt;
      end
      // Final capture lands on the same edge, so compare the next-state table.
      if (w_done_entry) r_pass <= (w_result_nxt == GOLDEN);
    end
  end

`ifdef Q1_SWEEP_ERRCNT_EN
  logic [4:0] r_err_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_err_cnt <= '0;
    else if (w_start_acc)  r_err_cnt <= '0;
    else if (w_done_entry) r_err_cnt <= q1_popcount(w_result_nxt ^ GOLDEN);
  end
  assign bus.err_cnt = r_err_cnt;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.ext_gnt = bus.ext_req & (r_state == IDLE) & ~bus.start & ~rst;
  assign bus.ext_f   = bus.ext_gnt & w_f;
  assign bus.busy    = w_busy;
  assign bus.done    = (r_state == DONE);
  assign bus.pass    = r_pass;
  assign bus.result  = r_result;

endmodule

// File: tb/tb_q1_sweep_ctrl.sv
// Scoreboard bench for q1_sweep_ctrl: two instances (default golden and 16'hF831) share stimulus.
module tb_q1_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ext_req = 1'b0;
  logic [3:0] ext_abcd = 4'd0;

  always #5 clk = ~clk;

  q1_sweep_ctrl_if b0 ();
  q1_sweep_ctrl_if b1 ();

  assign b0.start = start;  assign b0.ext_req = ext_req;  assign b0.ext_abcd = ext_abcd;
  assign b1.start = start;  assign b1.ext_req = ext_req;  assign b1.ext_abcd = ext_abcd;

  q1_sweep_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  q1_sweep_ctrl #(.GOLDEN(16'hF831)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [15:0] tt;
    logic        pass0;
    logic [4:0]  err0;
    logic        pass1;
    logic [4:0]  err1;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   phase = -1;     // edges since accepted start; -1 when idle
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic f_ref(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a && (b || (c && d))) || (b && !c);
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    for (int n = 0; n < 16; n++) e.tt[n] = f_ref(4'(n));
    e.pass0 = (e.tt == 16'hF830);
    e.pass1 = (e.tt == 16'hF831);
`ifdef Q1_SWEEP_ERRCNT_EN
    e.err0 = 5'($countones(e.tt ^ 16'hF830));
    e.err1 = 5'($countones(e.tt ^ 16'hF831));
`else
    e.err0 = 5'd0;
    e.err1 = 5'd0;
`endif
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.tt = '0; e.pass0 = 1'b0; e.err0 = '0; e.pass1 = 1'b0; e.err1 = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Reference model: sweep occupies 17 edges after acceptance, then one DONE cycle.
  always @(posedge clk) begin
    bit was_idle;
    if (rst) begin
      phase = -1;
      sb.delete();
      held = zero_exp();
    end else begin
      was_idle = (phase < 0);
      if (!was_idle) begin
        phase++;
        if (phase >= 18) phase = -1;
      end
      if (was_idle && start) begin
        phase = 0;
        sb.push_back(make_exp());
      end
      if (phase == 17) held = make_exp();
    end
  end

  // Monitor: mid-cycle sampling of both instances.
  always @(negedge clk) begin
    bit   idle_e, gnt_e;
    exp_t e;
    if (rst) begin
      chk("rst_busy",   32'(b0.busy),    0);
      chk("rst_done",   32'(b0.done),    0);
      chk("rst_gnt",    32'(b0.ext_gnt), 0);
      chk("rst_f",      32'(b0.ext_f),   0);
      chk("rst_result", 32'(b0.result),  0);
      chk("rst_pass",   32'(b0.pass),    0);
      chk("rst_err",    32'(b0.err_cnt), 0);
      chk("rst_result1",32'(b1.result),  0);
    end else begin
      idle_e = (phase < 0);
      gnt_e  = ext_req && idle_e && !start;
      chk("busy",  32'(b0.busy),    32'(phase >= 0 && phase <= 16));
      chk("done",  32'(b0.done),    32'(phase == 17));
      chk("done1", 32'(b1.done),    32'(phase == 17));
      chk("gnt",   32'(b0.ext_gnt), 32'(gnt_e));
      chk("ext_f", 32'(b0.ext_f),   32'(gnt_e && f_ref(ext_abcd)));
      if (!(phase >= 0 && phase <= 16)) begin
        chk("held_result", 32'(b0.result),  32'(held.tt));
        chk("held_pass0",  32'(b0.pass),    32'(held.pass0));
        chk("held_err0",   32'(b0.err_cnt), 32'(held.err0));
        chk("held_pass1",  32'(b1.pass),    32'(held.pass1));
        chk("held_err1",   32'(b1.err_cnt), 32'(held.err1));
      end
      if (b0.done) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_pop at %0t: done seen with empty scoreboard", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_result0", 32'(b0.result),  32'(e.tt));
          chk("sb_result1", 32'(b1.result),  32'(e.tt));
          chk("sb_pass0",   32'(b0.pass),    32'(e.pass0));
          chk("sb_err0",    32'(b0.err_cnt), 32'(e.err0));
          chk("sb_pass1",   32'(b1.pass),    32'(e.pass1));
          chk("sb_err1",    32'(b1.err_cnt), 32'(e.err1));
        end
      end
    end
  end

  task automatic drive(input bit st, input bit rq, input logic [3:0] ab, input bit rs);
    start = st; ext_req = rq; ext_abcd = ab; rst = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    held = zero_exp();
    #2;
    repeat (3) drive(0, 1, 4'b1011, 1);
    drive(0, 1, 4'b1011, 0);
    drive(0, 1, 4'b0110, 0);
    drive(0, 0, 4'b0000, 0);
    // start with a competing request; a second start at t+5 must be ignored
    drive(1, 1, 4'b1011, 0);
    for (int i = 1; i <= 20; i++) drive(i == 5, 1, 4'($urandom_range(0, 15)), 0);
    // reset in the middle of a sweep, then a clean sweep
    drive(1, 0, 4'b0000, 0);
    for (int i = 1; i <= 7; i++) drive(0, 1, 4'($urandom_range(0, 15)), 0);
    drive(0, 1, 4'b1111, 1);
    drive(0, 1, 4'b1111, 1);
    drive(1, 1, 4'b0100, 0);
    for (int i = 0; i < 20; i++) drive(0, 1, 4'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 7) == 0, 1'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, 99) == 0);
    repeat (25) drive(0, 1, 4'($urandom_range(0, 15)), 0);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
